// File: rtl/turn_timer_pkg.sv
// Shared types and width helpers for the turn timeout timer.
package turn_timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } turn_state_t;

    function automatic int player_width(input int n_players);
        return ($clog2(n_players) < 1) ? 1 : $clog2(n_players);
    endfunction

    function automatic int secs_width(input int timeout_s);
        return $clog2(timeout_s + 1);
    endfunction

    function automatic int prescaler_width(input int clk_hz);
        return $clog2(clk_hz);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every CLK_HZ counted cycles.
module tick_prescaler
    import turn_timer_pkg::*;
#(
    parameter int  CLK_HZ = 50_000_000,
    localparam int CW     = prescaler_width(CLK_HZ)
) (
    input  logic clk,
    input  logic reset_game,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam logic [CW-1:0] COUNT_LAST = CW'(CLK_HZ - 1);

    logic [CW-1:0] count_r;

    // Tick marks the cycle whose edge wraps the count back to zero.
    always_comb begin
        tick = run && (count_r == COUNT_LAST);
    end

    // Prescaler count: clear wins, otherwise count only while running.
    always_ff @(posedge clk or posedge reset_game) begin
        if (reset_game) begin
            count_r <= {CW{1'b0}};
        end else if (clear) begin
            count_r <= {CW{1'b0}};
        end else if (run) begin
            if (count_r == COUNT_LAST) begin
                count_r <= {CW{1'b0}};
            end else begin
                count_r <= count_r + CW'(1);
            end
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/turn_timer_param_check.sv
// Elaboration-time legality checks on the turn timer parameters.
module turn_timer_param_check #(
    parameter int CLK_HZ    = 2,
    parameter int TIMEOUT_S = 2,
    parameter int WARN_S    = 1,
    parameter int N_PLAYERS = 2
) ();

    generate
        if (CLK_HZ < 2) begin : g_bad_clk_hz
            $error("turn_timeout_timer: CLK_HZ must be at least 2");
        end
        if (TIMEOUT_S < 1) begin : g_bad_timeout
            $error("turn_timeout_timer: TIMEOUT_S must be at least 1");
        end
        if ((WARN_S < 1) || (WARN_S >= TIMEOUT_S)) begin : g_bad_warn
            $error("turn_timeout_timer: WARN_S must satisfy 1 <= WARN_S < TIMEOUT_S");
        end
        if (N_PLAYERS < 2) begin : g_bad_players
            $error("turn_timeout_timer: N_PLAYERS must be at least 2");
        end
    endgenerate

endmodule

// File: rtl/turn_timeout_timer.sv
// Per-turn timeout: seconds countdown, expiry request pulse and player tracking.
// Optional low-time warning output enabled by defining TURN_TIMER_WARN_EN.
module turn_timeout_timer
    import turn_timer_pkg::*;
#(
    parameter int  CLK_HZ    = 50_000_000,
    parameter int  TIMEOUT_S = 30,
    parameter int  WARN_S    = 5,
    parameter int  N_PLAYERS = 2,
    localparam int PW        = player_width(N_PLAYERS),
    localparam int SW        = secs_width(TIMEOUT_S)
) (
    input  logic          clk,
    input  logic          reset_game,
    input  logic          enable,
    input  logic          pause,
    input  logic          next_turn,
    output logic          gen_turn,
    output logic [PW-1:0] player,
    output logic [SW-1:0] secs_left,
    output logic          warn
);

    localparam logic [SW-1:0] SECS_RELOAD = SW'(TIMEOUT_S);
    localparam logic [PW-1:0] LAST_PLAYER = PW'(N_PLAYERS - 1);

    turn_state_t   state_r, state_s;
    logic [SW-1:0] secs_r, secs_s;
    logic [PW-1:0] player_r, player_s, player_inc_s;
    logic          gen_r, gen_s;
    logic          run_s, clear_s, tick_s;

    turn_timer_param_check #(
        .CLK_HZ    (CLK_HZ),
        .TIMEOUT_S (TIMEOUT_S),
        .WARN_S    (WARN_S),
        .N_PLAYERS (N_PLAYERS)
    ) u_param_check ();

    tick_prescaler #(
        .CLK_HZ (CLK_HZ)
    ) u_prescaler (
        .clk        (clk),
        .reset_game (reset_game),
        .run        (run_s),
        .clear      (clear_s),
        .tick       (tick_s)
    );

    // Prescaler control; a PAUSED cycle with pause released already counts.
    always_comb begin
        clear_s = (!enable) || (state_r == IDLE) || next_turn;
        run_s   = enable && !next_turn && !pause &&
                  ((state_r == RUN) || (state_r == PAUSED));
    end

    // Player index wraps from the last player back to 0.
    always_comb begin
        if (player_r == LAST_PLAYER) begin
            player_inc_s = {PW{1'b0}};
        end else begin
            player_inc_s = player_r + PW'(1);
        end
    end

    // Next-state, countdown and expiry request, in priority order.
    always_comb begin
        state_s  = state_r;
        secs_s   = secs_r;
        player_s = player_r;
        gen_s    = 1'b0;
        if (!enable) begin
            state_s  = IDLE;
            secs_s   = SECS_RELOAD;
            player_s = next_turn ? player_inc_s : player_r;
        end else if ((state_r == IDLE) || next_turn) begin
            state_s  = pause ? PAUSED : RUN;
            secs_s   = SECS_RELOAD;
            player_s = next_turn ? player_inc_s : player_r;
        end else begin
            case (state_r)
                RUN, PAUSED: begin
                    if (pause) begin
                        state_s = PAUSED;
                    end else begin
                        state_s = RUN;
                        if (tick_s) begin
                            if (secs_r <= SW'(1)) begin
                                secs_s  = {SW{1'b0}};
                                gen_s   = 1'b1;
                                state_s = EXPIRED;
                            end else begin
                                secs_s = secs_r - SW'(1);
                            end
                        end else begin
                            secs_s = secs_r;
                        end
                    end
                end
                EXPIRED: begin
                    state_s = EXPIRED;
                    secs_s  = {SW{1'b0}};
                end
                default: begin
                    state_s = IDLE;
                    secs_s  = SECS_RELOAD;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset_game) begin
        if (reset_game) begin
            state_r  <= IDLE;
            secs_r   <= SECS_RELOAD;
            player_r <= {PW{1'b0}};
            gen_r    <= 1'b0;
        end else begin
            state_r  <= state_s;
            secs_r   <= secs_s;
            player_r <= player_s;
            gen_r    <= gen_s;
        end
    end

    assign gen_turn  = gen_r;
    assign player    = player_r;
    assign secs_left = secs_r;

`ifdef TURN_TIMER_WARN_EN
    localparam logic [SW-1:0] WARN_LEVEL = SW'(WARN_S);

    logic warn_r, warn_s;

    // Warning follows the upcoming state and count so it lines up with secs_left.
    always_comb begin
        warn_s = ((state_s == RUN) || (state_s == PAUSED)) &&
                 (secs_s != {SW{1'b0}}) && (secs_s <= WARN_LEVEL);
    end

    // Warning register.
    always_ff @(posedge clk or posedge reset_game) begin
        if (reset_game) begin
            warn_r <= 1'b0;
        end else begin
            warn_r <= warn_s;
        end
    end

    assign warn = warn_r;
`else
    assign warn = 1'b0;
`endif

endmodule

// File: tb/tb_turn_timeout_timer.sv
// Self-checking bench for turn_timeout_timer (CLK_HZ=4, TIMEOUT_S=3, WARN_S=1, N_PLAYERS=3).
module tb_turn_timeout_timer;

    localparam int CLK_HZ    = 4;
    localparam int TIMEOUT_S = 3;
    localparam int WARN_S    = 1;
    localparam int N_PLAYERS = 3;
    localparam int TURN_CYC  = TIMEOUT_S * CLK_HZ;

`ifdef TURN_TIMER_WARN_EN
    localparam logic WARN_ON = 1'b1;
`else
    localparam logic WARN_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_game;
    logic       enable;
    logic       pause;
    logic       next_turn;
    logic       gen_turn;
    logic [1:0] player;
    logic [1:0] secs_left;
    logic       warn;

    typedef struct packed {
        logic       gen;
        logic [1:0] player;
        logic [1:0] secs;
        logic       warn;
    } exp_t;

    typedef struct {
        logic en;
        logic pa;
        logic nt;
        logic g;
        int   p;
        int   s;
        logic w;
    } vec_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    turn_timeout_timer #(
        .CLK_HZ    (CLK_HZ),
        .TIMEOUT_S (TIMEOUT_S),
        .WARN_S    (WARN_S),
        .N_PLAYERS (N_PLAYERS)
    ) dut (
        .clk        (clk),
        .reset_game (reset_game),
        .enable     (enable),
        .pause      (pause),
        .next_turn  (next_turn),
        .gen_turn   (gen_turn),
        .player     (player),
        .secs_left  (secs_left),
        .warn       (warn)
    );

    always #5 clk = ~clk;

    function automatic int secs_at(input int k);
        return TIMEOUT_S - (k / CLK_HZ);
    endfunction

    function automatic logic warn_at(input int s);
        return (s >= 1) && (s <= WARN_S);
    endfunction

    task automatic compare_now(input string tag, input exp_t e);
        n_vec++;
        if ({gen_turn, player, secs_left, warn} !== e) begin
            n_err++;
            $display("FAIL %s: got gen=%0b player=%0d secs=%0d warn=%0b, want gen=%0b player=%0d secs=%0d warn=%0b",
                     tag, gen_turn, player, secs_left, warn, e.gen, e.player, e.secs, e.warn);
        end
    endtask

    // Drive one cycle of inputs, queue its expectation, check after the edge.
    task automatic step(input string tag, input logic en, input logic pa, input logic nt,
                        input logic g, input int p, input int s, input logic w);
        exp_t e;
        enable    = en;
        pause     = pa;
        next_turn = nt;
        e.gen    = g;
        e.player = p[1:0];
        e.secs   = s[1:0];
        e.warn   = w & WARN_ON;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        compare_now(tag, e);
    endtask

    // One turn: reload cycle, then RUN cycles 1..last_k with an optional pause window.
    task automatic run_turn(input string tag, input logic nt0, input logic pa0, input int p,
                            input int pause_at, input int pause_len, input int last_k);
        step(tag, 1'b1, pa0, nt0, 1'b0, p, TIMEOUT_S, 1'b0);
        for (int k = 1; k <= last_k; k++) begin
            if (k - 1 == pause_at) begin
                for (int j = 0; j < pause_len; j++) begin
                    step(tag, 1'b1, 1'b1, 1'b0, 1'b0, p, secs_at(k - 1), warn_at(secs_at(k - 1)));
                end
            end
            step(tag, 1'b1, 1'b0, 1'b0, (k == TURN_CYC), p, secs_at(k), warn_at(secs_at(k)));
        end
    endtask

    initial begin
        vec_t tbl[16];
        exp_t rst_e;

        // First turn from reset: reload, 12 RUN cycles, expiry, hold in EXPIRED.
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 3, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 3, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 3, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 3, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 2, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 2, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 2, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 2, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 1, 1'b1};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 1, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 1, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 1, 1'b1};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0};
        tbl[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0};

        reset_game = 1'b1;
        enable     = 1'b0;
        pause      = 1'b0;
        next_turn  = 1'b0;
        rst_e      = '{gen: 1'b0, player: 2'd0, secs: 2'd3, warn: 1'b0};

        repeat (2) @(posedge clk);
        #1;
        compare_now("reset_values", rst_e);
        reset_game = 1'b0;

        for (int i = 0; i < 16; i++) begin
            step("first_turn", tbl[i].en, tbl[i].pa, tbl[i].nt, tbl[i].g, tbl[i].p, tbl[i].s, tbl[i].w);
        end

        // next_turn from EXPIRED advances and wraps the player.
        run_turn("expire_p1", 1'b1, 1'b0, 1, -1, 0, TURN_CYC);
        run_turn("expire_p2", 1'b1, 1'b0, 2, -1, 0, TURN_CYC);
        run_turn("expire_p0", 1'b1, 1'b0, 0, -1, 0, TURN_CYC);

        // Pause for 7 cycles after 5 RUN cycles: expiry lands 19 cycles after entry.
        run_turn("pause_mid", 1'b1, 1'b0, 1, 5, 7, TURN_CYC);
        // Pause inside the warning window, then stop one cycle before the last tick.
        run_turn("warn_paused", 1'b1, 1'b0, 2, 9, 2, TURN_CYC - 1);
        // next_turn on the expiring tick: no request, player wraps 2 -> 0.
        run_turn("nt_on_tick", 1'b1, 1'b0, 0, -1, 0, 4);
        // pause together with next_turn: reload into PAUSED, then resume.
        run_turn("pause_and_nt", 1'b1, 1'b1, 1, 0, 3, TURN_CYC);

        // enable low mid-turn: IDLE with reload, player kept; next_turn in IDLE advances.
        run_turn("pre_disable", 1'b1, 1'b0, 2, -1, 0, 6);
        step("disable", 1'b0, 1'b0, 1'b0, 1'b0, 2, 3, 1'b0);
        step("idle_hold", 1'b0, 1'b1, 1'b0, 1'b0, 2, 3, 1'b0);
        step("idle_next", 1'b0, 1'b0, 1'b1, 1'b0, 0, 3, 1'b0);
        run_turn("re_enable", 1'b0, 1'b0, 0, -1, 0, 5);

        // Asynchronous reset between edges clears outputs before the next edge.
        run_turn("pre_reset", 1'b1, 1'b0, 1, -1, 0, 9);
        #2;
        reset_game = 1'b1;
        #1;
        compare_now("async_reset", rst_e);
        @(posedge clk);
        #1;
        reset_game = 1'b0;
        run_turn("after_reset", 1'b0, 1'b0, 0, -1, 0, TURN_CYC + 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
